// File: rtl/tick_edge_monitor.sv
// Synchronizes one divided clock into clk, emits rise/fall strobes and checks
// every half period against EXP_HALF +/- TOL, with lock tracking and error count.
module tick_edge_monitor #(
  parameter int SYNC_STAGES = 2,
  parameter int EXP_HALF    = 25000,
  parameter int TOL         = 16,
  parameter int LOCK_COUNT  = 4,
  parameter int CNT_W       = 26
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick_in,
  input  logic             enable,
  input  logic             clr_err,
  output logic             rise_pulse,
  output logic             fall_pulse,
  output logic [CNT_W-1:0] half_period,
  output logic             period_valid,
  output logic             too_fast,
  output logic             too_slow,
  output logic             locked,
  output logic [7:0]       err_count
);

  localparam int GOOD_W = $clog2(LOCK_COUNT + 1);
  localparam logic [CNT_W-1:0]  LO_LIM  = CNT_W'(EXP_HALF - TOL);
  localparam logic [CNT_W-1:0]  HI_LIM  = CNT_W'(EXP_HALF + TOL);
  localparam logic [CNT_W-1:0]  SAT_LIM = CNT_W'(EXP_HALF + TOL + 1);
  localparam logic [GOOD_W-1:0] GOOD_LOCK = GOOD_W'(LOCK_COUNT);

  typedef enum logic [1:0] {IDLE, ARM, MEASURE, LOCKED} state_t;

  function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] c);
    return (c >= SAT_LIM) ? SAT_LIM : c + CNT_W'(1);
  endfunction

  function automatic logic [7:0] err_inc(input logic [7:0] e);
    return (e == 8'hFF) ? 8'hFF : e + 8'd1;
  endfunction

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s_d_q;
  state_t                 state_q;
  logic [CNT_W-1:0]       cnt_q;
  logic [CNT_W-1:0]       half_q;
  logic [GOOD_W-1:0]      good_q;
  logic                   rise_q, fall_q, pv_q, fast_q, slow_q, locked_q;
  logic [7:0]             err_q, err_d;

  logic s, tog, is_fast, is_slow, measuring, err_ev;

  // Synchronizer stage: the chain and previous-sample flop always run.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      s_d_q  <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], tick_in};
      s_d_q  <= s;
    end
  end

  always_comb begin
    s         = sync_q[SYNC_STAGES-1];
    tog       = s ^ s_d_q;
    is_fast   = cnt_q < LO_LIM;
    is_slow   = cnt_q > HI_LIM;
    measuring = (state_q == MEASURE) || (state_q == LOCKED);
    // An edge wins over a timeout landing in the same cycle.
    err_ev    = enable && measuring &&
                (tog ? (is_fast || is_slow) : (cnt_q == SAT_LIM));
    err_d     = err_q;
    if (clr_err)     err_d = err_ev ? 8'd1 : 8'd0;
    else if (err_ev) err_d = err_inc(err_q);
  end

  // Measurement / lock stage: all outputs registered here.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      half_q   <= '0;
      good_q   <= '0;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
      pv_q     <= 1'b0;
      fast_q   <= 1'b0;
      slow_q   <= 1'b0;
      locked_q <= 1'b0;
      err_q    <= 8'd0;
    end else begin
      rise_q <= 1'b0;
      fall_q <= 1'b0;
      pv_q   <= 1'b0;
      fast_q <= 1'b0;
      slow_q <= 1'b0;
      err_q  <= err_d;
      if (!enable) begin
        state_q  <= IDLE;
        cnt_q    <= '0;
        good_q   <= '0;
        locked_q <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            state_q  <= ARM;
            cnt_q    <= '0;
            good_q   <= '0;
            locked_q <= 1'b0;
          end
          ARM: begin
            rise_q <= s & ~s_d_q;
            fall_q <= ~s & s_d_q;
            if (tog) begin
              cnt_q   <= CNT_W'(1);
              state_q <= MEASURE;
            end else begin
              cnt_q <= cnt_inc(cnt_q);
            end
          end
          MEASURE, LOCKED: begin
            rise_q <= s & ~s_d_q;
            fall_q <= ~s & s_d_q;
            if (tog) begin
              cnt_q  <= CNT_W'(1);
              half_q <= cnt_q;
              pv_q   <= 1'b1;
              if (is_fast || is_slow) begin
                fast_q   <= is_fast;
                slow_q   <= is_slow;
                good_q   <= '0;
                locked_q <= 1'b0;
                state_q  <= MEASURE;
              end else if (good_q >= GOOD_LOCK - GOOD_W'(1)) begin
                good_q   <= GOOD_LOCK;
                locked_q <= 1'b1;
                state_q  <= LOCKED;
              end else begin
                good_q <= good_q + GOOD_W'(1);
              end
            end else if (cnt_q == SAT_LIM) begin
              // Missing toggle: report once, then rearm for a fresh first edge.
              slow_q   <= 1'b1;
              good_q   <= '0;
              locked_q <= 1'b0;
              state_q  <= ARM;
            end else begin
              cnt_q <= cnt_inc(cnt_q);
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign rise_pulse   = rise_q;
  assign fall_pulse   = fall_q;
  assign half_period  = half_q;
  assign period_valid = pv_q;
  assign too_fast     = fast_q;
  assign too_slow     = slow_q;
  assign locked       = locked_q;
  assign err_count    = err_q;

endmodule

// File: tb/tb_tick_edge_monitor.sv
// Bench for tick_edge_monitor: per-cycle comparison against a timestamp-based
// reference model plus directed checks for each scenario.
module tb_tick_edge_monitor;
  localparam int SS = 2, EH = 10, TL = 1, LC = 3, CW = 8;
  localparam int MAXC = EH + TL + 1;

  logic clk = 1'b0;
  logic rst = 1'b1, tick_in = 1'b0, enable = 1'b0, clr_err = 1'b0;
  logic rise_pulse, fall_pulse, period_valid, too_fast, too_slow, locked;
  logic [CW-1:0] half_period;
  logic [7:0] err_count;

  tick_edge_monitor #(.SYNC_STAGES(SS), .EXP_HALF(EH), .TOL(TL),
                      .LOCK_COUNT(LC), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .tick_in(tick_in), .enable(enable), .clr_err(clr_err),
    .rise_pulse(rise_pulse), .fall_pulse(fall_pulse), .half_period(half_period),
    .period_valid(period_valid), .too_fast(too_fast), .too_slow(too_slow),
    .locked(locked), .err_count(err_count));

  always #5 clk = ~clk;

  int total = 0, bad = 0;
  int cyc = 0, last_rst = -1;
  bit samp[$];
  // Model: mode 0 idle, 1 waiting for first edge, 2 measuring; m_e = cycle of last edge.
  int m_mode = 0, m_e = 0, m_good = 0, m_err = 0, m_half = 0;
  bit m_rise, m_fall, m_pv, m_tf, m_ts, m_locked;
  int ndiff = 0, d_cyc = 0;
  logic [21:0] d_obs, d_exp;
  int n_ts = 0, n_pv = 0, n_strobe = 0;

  function automatic bit sval(int i);
    if (i < 0 || i <= last_rst) return 1'b0;
    return samp[i];
  endfunction

  task automatic step();
    bit s, sd, tg, errev;
    int n;
    logic [21:0] obs, expv;
    @(posedge clk);
    samp.push_back(tick_in);
    m_rise = 0; m_fall = 0; m_pv = 0; m_tf = 0; m_ts = 0;
    if (rst) begin
      last_rst = cyc;
      m_mode = 0; m_good = 0; m_locked = 0; m_err = 0; m_half = 0;
    end else begin
      s = sval(cyc - SS); sd = sval(cyc - SS - 1); tg = s ^ sd; errev = 0;
      if (!enable) begin
        m_mode = 0; m_good = 0; m_locked = 0;
      end else if (m_mode == 0) begin
        m_mode = 1;
      end else begin
        m_rise = tg && s; m_fall = tg && !s;
        if (m_mode == 1) begin
          if (tg) begin m_e = cyc; m_mode = 2; end
        end else if (tg) begin
          n = cyc - m_e; if (n > MAXC) n = MAXC;
          m_half = n; m_pv = 1; m_e = cyc;
          if (n < EH - TL) begin m_tf = 1; errev = 1; end
          else if (n > EH + TL) begin m_ts = 1; errev = 1; end
          else begin m_good++; if (m_good >= LC) m_locked = 1; end
          if (errev) begin m_good = 0; m_locked = 0; end
        end else if (cyc - m_e >= MAXC) begin
          m_ts = 1; errev = 1; m_good = 0; m_locked = 0; m_mode = 1;
        end
      end
      if (clr_err) m_err = errev;
      else if (errev && m_err < 255) m_err++;
    end
    cyc++;
    #1;
    obs  = {rise_pulse, fall_pulse, period_valid, too_fast, too_slow, locked,
            err_count, half_period};
    expv = {m_rise, m_fall, m_pv, m_tf, m_ts, m_locked, 8'(m_err), 8'(m_half)};
    if (obs !== expv) begin
      if (ndiff == 0) begin d_cyc = cyc; d_obs = obs; d_exp = expv; end
      ndiff++;
    end
    n_ts     += int'(too_slow === 1'b1);
    n_pv     += int'(period_valid === 1'b1);
    n_strobe += int'(rise_pulse === 1'b1) + int'(fall_pulse === 1'b1) +
                int'(period_valid === 1'b1);
  endtask

  task automatic drive_half(int n);
    tick_in = ~tick_in;
    repeat (n) step();
  endtask

  task automatic test_reset();
    rst = 1; enable = 0; tick_in = 0;
    repeat (3) step();
    total++;
    if ({rise_pulse, fall_pulse, period_valid, too_fast, too_slow, locked,
         err_count, half_period} !== 22'd0) begin
      bad++; $display("FAIL reset_outputs got err=%0d half=%0d locked=%b want all zero",
                      err_count, half_period, locked);
    end
  endtask

  task automatic test_lock();
    rst = 0; enable = 1;
    repeat ($urandom_range(2, 5)) step();
    tick_in = 1;
    repeat (3) step();
    total++;
    if (rise_pulse !== 1'b1 || period_valid !== 1'b0) begin
      bad++; $display("FAIL first_edge got rise=%b pv=%b want rise=1 pv=0",
                      rise_pulse, period_valid);
    end
    repeat (7) step();
    for (int i = 1; i <= 4; i++) begin
      drive_half(10);
      total++;
      if (ndiff != 0) begin
        bad++; $display("FAIL lock_trace cyc=%0d got=%h want=%h", d_cyc, d_obs, d_exp);
        ndiff = 0;
      end
      if (i == 2) begin
        total++;
        if (locked !== 1'b0) begin
          bad++; $display("FAIL lock_early got=%b want=0", locked);
        end
      end
      if (i == 3) begin
        total++;
        if (locked !== 1'b1 || err_count !== 8'd0 || half_period !== 8'd10) begin
          bad++; $display("FAIL lock_third got locked=%b err=%0d half=%0d want 1 0 10",
                          locked, err_count, half_period);
        end
      end
    end
  endtask

  task automatic test_too_fast();
    drive_half(7);
    for (int i = 1; i <= 4; i++) begin
      drive_half(10);
      total++;
      if (ndiff != 0) begin
        bad++; $display("FAIL fast_trace cyc=%0d got=%h want=%h", d_cyc, d_obs, d_exp);
        ndiff = 0;
      end
      if (i == 1) begin
        total++;
        if (half_period !== 8'd7 || err_count !== 8'd1 || locked !== 1'b0) begin
          bad++; $display("FAIL fast_meas got half=%0d err=%0d locked=%b want 7 1 0",
                          half_period, err_count, locked);
        end
      end
      if (i == 3 || i == 4) begin
        total++;
        if (locked !== (i == 4)) begin
          bad++; $display("FAIL relock half=%0d got=%b want=%0d", i, locked, i == 4);
        end
      end
    end
  endtask

  task automatic test_timeout();
    n_ts = 0;
    repeat (30) step();
    total++;
    if (n_ts !== 1 || err_count !== 8'd2 || locked !== 1'b0 || ndiff != 0) begin
      bad++; $display("FAIL timeout got slow=%0d err=%0d locked=%b diffs=%0d want 1 2 0 0",
                      n_ts, err_count, locked, ndiff);
      ndiff = 0;
    end
    n_pv = 0;
    drive_half(10);
    drive_half(10);
    total++;
    if (n_pv !== 1 || half_period !== 8'd10 || err_count !== 8'd2 || ndiff != 0) begin
      bad++; $display("FAIL resume got pv=%0d half=%0d err=%0d want 1 10 2",
                      n_pv, half_period, err_count);
      ndiff = 0;
    end
  endtask

  task automatic test_range();
    int lens[4] = '{9, 11, 12, 10};
    for (int i = 0; i < 4; i++) begin
      n_ts = 0;
      drive_half(lens[i]);
      total++;
      if (ndiff != 0) begin
        bad++; $display("FAIL range_trace cyc=%0d got=%h want=%h", d_cyc, d_obs, d_exp);
        ndiff = 0;
      end
      if (i >= 1) begin
        total++;
        if (half_period !== 8'(lens[i-1]) || err_count !== ((i == 3) ? 8'd3 : 8'd2) ||
            n_ts !== int'(i == 3)) begin
          bad++; $display("FAIL range_meas got half=%0d err=%0d slow=%0d want %0d",
                          half_period, err_count, n_ts, lens[i-1]);
        end
      end
    end
  endtask

  task automatic test_err_sat();
    while (m_err < 5) drive_half(3);
    tick_in = ~tick_in;
    step(); step();
    clr_err = 1;
    step();
    clr_err = 0;
    total++;
    if (too_fast !== 1'b1 || err_count !== 8'd1) begin
      bad++; $display("FAIL clr_with_err got fast=%b err=%0d want 1 1", too_fast, err_count);
    end
    repeat (300) drive_half(2);
    total++;
    if (err_count !== 8'd255 || ndiff != 0) begin
      bad++; $display("FAIL err_sat got err=%0d diffs=%0d want 255 0", err_count, ndiff);
      ndiff = 0;
    end
  endtask

  task automatic test_disable();
    repeat (5) drive_half(10);
    total++;
    if (locked !== 1'b1) begin
      bad++; $display("FAIL pre_disable_lock got=%b want=1", locked);
    end
    enable = 0;
    step();
    total++;
    if (locked !== 1'b0 || err_count !== 8'd255) begin
      bad++; $display("FAIL disable got locked=%b err=%0d want 0 255", locked, err_count);
    end
    n_strobe = 0;
    drive_half(10); drive_half(10);
    total++;
    if (n_strobe !== 0 || ndiff != 0) begin
      bad++; $display("FAIL disabled_quiet got strobes=%0d diffs=%0d want 0 0", n_strobe, ndiff);
      ndiff = 0;
    end
    enable = 1;
    drive_half(10); drive_half(10); drive_half(5);
    rst = 1;
    step();
    rst = 0;
    total++;
    if ({rise_pulse, fall_pulse, period_valid, too_fast, too_slow, locked,
         err_count, half_period} !== 22'd0) begin
      bad++; $display("FAIL mid_reset got err=%0d half=%0d locked=%b want all zero",
                      err_count, half_period, locked);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    for (int i = 0; i < 150; i++) begin
      n = $urandom_range(2, 14);
      tick_in = ~tick_in;
      for (int j = 0; j < n; j++) begin
        clr_err = ($urandom_range(0, 15) == 0);
        enable  = ($urandom_range(0, 60) != 0);
        step();
      end
      total++;
      if (ndiff != 0) begin
        bad++; $display("FAIL random_trace cyc=%0d got=%h want=%h", d_cyc, d_obs, d_exp);
        ndiff = 0;
      end
    end
    clr_err = 0;
    enable  = 1;
  endtask

  initial begin
    test_reset();
    test_lock();
    test_too_fast();
    test_timeout();
    test_range();
    test_err_sat();
    test_disable();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
